// File: rtl/outpkt_pkg.sv
// Shared definitions for the output packet transmitter: state encoding,
// framing word counts, default protocol constants and the header word mux.
package outpkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BODY  = 3'd2,
        ST_CK_LO = 3'd3,
        ST_CK_HI = 3'd4
    } state_t;

    localparam int          HDR_WORDS       = 4;
    localparam int          CK_WORDS        = 2;
    localparam logic [1:0]  HDR_LAST_IDX    = 2'd3;
    localparam logic [7:0]  VERSION_DEFAULT = 8'h02;
    localparam logic [15:0] MAX_LEN_DEFAULT = 16'd4096;

    // Header word selected by index: W0 type/version, W1 id, W2 length, W3 reserved.
    function automatic logic [15:0] hdr_word(
        input logic [1:0]  idx,
        input logic [7:0]  ptype,
        input logic [7:0]  version,
        input logic [15:0] id,
        input logic [15:0] len
    );
        logic [15:0] w;
        case (idx)
            2'd0:    w = {ptype, version};
            2'd1:    w = id;
            2'd2:    w = len;
            2'd3:    w = 16'h0000;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/outpkt_tx_checksum.sv
// 32-bit additive checksum over transmitted header/body words; the
// inverted halves are presented directly as the two trailer words.
module outpkt_tx_checksum
    import outpkt_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        clr,
    input  logic        add,
    input  logic [15:0] word,
    output logic [15:0] ck_lo,
    output logic [15:0] ck_hi
);

    logic [31:0] sum_r;

    // Accumulate zero-extended words modulo 2^32; clear takes priority.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sum_r <= 32'h0000_0000;
        end else if (clr) begin
            sum_r <= 32'h0000_0000;
        end else if (add) begin
            sum_r <= sum_r + {16'h0000, word};
        end else begin
            sum_r <= sum_r;
        end
    end

    assign ck_lo = ~sum_r[15:0];
    assign ck_hi = ~sum_r[31:16];

endmodule

// File: rtl/outpkt_tx.sv
// Output packet transmitter: frames header, FWFT-sourced body and checksum
// trailer as 16-bit words into the output FIFO, honouring full/empty.
module outpkt_tx
    import outpkt_pkg::*;
#(
    parameter logic [7:0]  VERSION = VERSION_DEFAULT,
    parameter logic [15:0] MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [7:0]  pkt_type,
    input  logic [15:0] pkt_id,
    input  logic [15:0] pkt_len,
    output logic        busy,
    output logic        err_len,
    input  logic [15:0] din,
    input  logic        empty,
    output logic        rd_en,
    output logic [15:0] dout,
    output logic        wr_en,
    input  logic        full,
    output logic [15:0] pkt_count
);

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  hdr_idx_r;
    logic [15:0] remaining_r;
    logic [7:0]  type_r;
    logic [15:0] id_r;
    logic [15:0] len_r;
    logic        busy_r;
    logic        err_len_r;
    logic [15:0] pkt_count_r;

    logic        start_idle_s;
    logic        accept_s;
    logic        reject_s;
    logic        wr_en_s;
    logic        rd_en_s;
    logic [15:0] dout_s;
    logic        sum_add_s;
    logic [15:0] ck_lo_s;
    logic [15:0] ck_hi_s;

    assign start_idle_s = (state_r == ST_IDLE) && start;
    assign accept_s     = start_idle_s && (pkt_len <= MAX_LEN);
    assign reject_s     = start_idle_s && (pkt_len > MAX_LEN);
    assign sum_add_s    = wr_en_s && ((state_r == ST_HDR) || (state_r == ST_BODY));

    outpkt_tx_checksum u_checksum (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (accept_s),
        .add   (sum_add_s),
        .word  (dout_s),
        .ck_lo (ck_lo_s),
        .ck_hi (ck_hi_s)
    );

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state and the combinational write/read strobes and output word.
    always_comb begin
        next_state_s = state_r;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        dout_s       = 16'h0000;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_HDR;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_HDR: begin
                wr_en_s = !full;
                dout_s  = hdr_word(hdr_idx_r, type_r, VERSION, id_r, len_r);
                if (!full && (hdr_idx_r == HDR_LAST_IDX)) begin
                    if (len_r == 16'd0) begin
                        next_state_s = ST_CK_LO;
                    end else begin
                        next_state_s = ST_BODY;
                    end
                end else begin
                    next_state_s = ST_HDR;
                end
            end
            ST_BODY: begin
                wr_en_s = !full && !empty;
                rd_en_s = !full && !empty;
                dout_s  = din;
                if (!full && !empty && (remaining_r == 16'd1)) begin
                    next_state_s = ST_CK_LO;
                end else begin
                    next_state_s = ST_BODY;
                end
            end
            ST_CK_LO: begin
                wr_en_s = !full;
                dout_s  = ck_lo_s;
                if (!full) begin
                    next_state_s = ST_CK_HI;
                end else begin
                    next_state_s = ST_CK_LO;
                end
            end
            ST_CK_HI: begin
                wr_en_s = !full;
                dout_s  = ck_hi_s;
                if (!full) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_CK_HI;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Latch packet fields on an accepted start.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            type_r <= 8'h00;
            id_r   <= 16'h0000;
            len_r  <= 16'h0000;
        end else if (accept_s) begin
            type_r <= pkt_type;
            id_r   <= pkt_id;
            len_r  <= pkt_len;
        end else begin
            type_r <= type_r;
            id_r   <= id_r;
            len_r  <= len_r;
        end
    end

    // Header index and body words-remaining counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hdr_idx_r   <= 2'd0;
            remaining_r <= 16'd0;
        end else if (accept_s) begin
            hdr_idx_r   <= 2'd0;
            remaining_r <= 16'd0;
        end else if ((state_r == ST_HDR) && wr_en_s) begin
            hdr_idx_r   <= hdr_idx_r + 2'd1;
            remaining_r <= len_r;
        end else if ((state_r == ST_BODY) && wr_en_s) begin
            hdr_idx_r   <= hdr_idx_r;
            remaining_r <= remaining_r - 16'd1;
        end else begin
            hdr_idx_r   <= hdr_idx_r;
            remaining_r <= remaining_r;
        end
    end

    // Busy flag, sticky length error and completed-packet counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            busy_r      <= 1'b0;
            err_len_r   <= 1'b0;
            pkt_count_r <= 16'd0;
        end else begin
            err_len_r <= err_len_r | reject_s;
            if (accept_s) begin
                busy_r      <= 1'b1;
                pkt_count_r <= pkt_count_r;
            end else if ((state_r == ST_CK_HI) && wr_en_s) begin
                busy_r      <= 1'b0;
                pkt_count_r <= pkt_count_r + 16'd1;
            end else begin
                busy_r      <= busy_r;
                pkt_count_r <= pkt_count_r;
            end
        end
    end

    assign busy      = busy_r;
    assign err_len   = err_len_r;
    assign pkt_count = pkt_count_r;
    assign wr_en     = wr_en_s;
    assign rd_en     = rd_en_s;
    assign dout      = dout_s;

endmodule
